// File: rtl/bicubic_pkg.sv
// rtl/bicubic_pkg.sv - shared constants, pass FSM encoding and clamp helper for the bicubic window feeder
package bicubic_pkg;

    localparam int NUM_SLOTS  = 5;
    localparam int NUM_PHASES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/bicubic_window_feeder_line_ram.sv
// rtl/bicubic_window_feeder_line_ram.sv - bicubic_line_ram: one source line, one write port, one registered read port
module bicubic_line_ram #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int DEPTH         = 960,
    parameter int AW            = 10
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [CHANNEL_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic [CHANNEL_WIDTH-1:0] rd_data
);

    logic [CHANNEL_WIDTH-1:0] mem [DEPTH];
    logic [CHANNEL_WIDTH-1:0] rd_data_q;

    // Read is registered straight from the array so the line maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bicubic_window_feeder.sv
// rtl/bicubic_window_feeder.sv - 4x4 clamped window generator for the bicubic upsampler
// Optional bf_req_last output enabled by defining BICUBIC_FEEDER_LAST_EN.
module bicubic_window_feeder
    import bicubic_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8,
    parameter int BLOCK_SIZE    = 960,
    parameter int SRC_HEIGHT    = 540
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     src_valid,
    output logic                     src_ready,
    input  logic [CHANNEL_WIDTH-1:0] src_data,
    output logic                     bf_req_valid,
    input  logic                     bcci_req_ready,
`ifdef BICUBIC_FEEDER_LAST_EN
    output logic                     bf_req_last,
`endif
    output logic [CHANNEL_WIDTH-1:0] p1,
    output logic [CHANNEL_WIDTH-1:0] p2,
    output logic [CHANNEL_WIDTH-1:0] p3,
    output logic [CHANNEL_WIDTH-1:0] p4,
    output logic [CHANNEL_WIDTH-1:0] p5,
    output logic [CHANNEL_WIDTH-1:0] p6,
    output logic [CHANNEL_WIDTH-1:0] p7,
    output logic [CHANNEL_WIDTH-1:0] p8,
    output logic [CHANNEL_WIDTH-1:0] p9,
    output logic [CHANNEL_WIDTH-1:0] p10,
    output logic [CHANNEL_WIDTH-1:0] p11,
    output logic [CHANNEL_WIDTH-1:0] p12,
    output logic [CHANNEL_WIDTH-1:0] p13,
    output logic [CHANNEL_WIDTH-1:0] p14,
    output logic [CHANNEL_WIDTH-1:0] p15,
    output logic [CHANNEL_WIDTH-1:0] p16
);

    localparam int W    = BLOCK_SIZE;
    localparam int H    = SRC_HEIGHT;
    localparam int AW   = (W > 1) ? $clog2(W) : 1;
    localparam int CW_W = $clog2(W + 1);
    localparam int RW_W = $clog2(H + 1);

    localparam logic [AW-1:0]   WCOL_LAST  = AW'(W - 1);
    localparam logic [CW_W-1:0] WC_LAST    = CW_W'(W);
    localparam logic [RW_W-1:0] ROW_LAST   = RW_W'(H - 1);
    localparam logic [RW_W-1:0] ROWS_ALL   = RW_W'(H);
    localparam logic [2:0]      LAST_SLOT  = 3'((H - 1) % NUM_SLOTS);
    localparam logic [1:0]      PHASE_LAST = 2'(NUM_PHASES - 1);

    state_e                       state_q, state_d;
    logic [1:0]                   prime_cnt_q, prime_cnt_d;
    logic [CW_W-1:0]              wc_q, wc_d;
    logic [RW_W-1:0]              wr_q, wr_d;
    logic [1:0]                   phase_q, phase_d;
    logic [2:0]                   wr_slot_q, wr_slot_d;
    logic [AW-1:0]                wcol_q, wcol_d;
    logic [RW_W-1:0]              wrow_q, wrow_d, wrow_acc;
    logic [2:0]                   w_slot_q, w_slot_d;
    logic                         src_ready_q, src_ready_d;
    logic                         valid_q, valid_d;
    logic [15:0][CHANNEL_WIDTH-1:0] win_q, win_d;

    logic                         accept;
    logic                         hs;
    logic                         frame_done;
    logic [AW-1:0]                rd_addr;
    logic [NUM_SLOTS-1:0]         ram_we;
    logic [CHANNEL_WIDTH-1:0]     rd_data [NUM_SLOTS];
    logic [3:0][CHANNEL_WIDTH-1:0] col_sel;
    int                           row_i;
    int                           slot_i;
    int                           next_wr;

    // A pass for target_wr needs rows 0..min(target_wr+1, H-1) fully written.
    function automatic logic rows_ready(input logic [RW_W-1:0] rows, input int target_wr);
        return int'(rows) > clamp(target_wr + 1, 0, H - 1);
    endfunction

    assign accept     = src_valid & src_ready_q;
    assign hs         = valid_q & bcci_req_ready;
    assign frame_done = hs && (wc_q == WC_LAST) && (phase_q == PHASE_LAST) && (wr_q == ROW_LAST);

    always_comb begin
        ram_we = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            ram_we[s] = accept && (w_slot_q == 3'(s));
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        bicubic_line_ram #(
            .CHANNEL_WIDTH(CHANNEL_WIDTH),
            .DEPTH        (W),
            .AW           (AW)
        ) u_line_ram (
            .clk    (clk),
            .wr_en  (ram_we[s]),
            .wr_addr(wcol_q),
            .wr_data(src_data),
            .rd_addr(rd_addr),
            .rd_data(rd_data[s])
        );
    end

    always_comb begin
        wcol_d   = wcol_q;
        wrow_acc = wrow_q;
        w_slot_d = w_slot_q;
        if (accept) begin
            if (wcol_q == WCOL_LAST) begin
                wcol_d   = '0;
                wrow_acc = wrow_q + 1'b1;
                w_slot_d = (w_slot_q == 3'd4) ? 3'd0 : w_slot_q + 3'd1;
            end else begin
                wcol_d = wcol_q + 1'b1;
            end
        end
        wrow_d = wrow_acc;
        if (frame_done) begin
            wcol_d   = '0;
            wrow_d   = '0;
            w_slot_d = '0;
        end
    end

    assign src_ready_d = (wrow_d < ROWS_ALL) && (int'(wrow_d) <= int'(wr_d) + 2);

    // Vertical clamping is pure slot selection: out-of-frame rows reuse slot of row 0 or row H-1.
    always_comb begin
        row_i   = 0;
        slot_i  = 0;
        col_sel = '0;
        for (int k = 0; k < 4; k++) begin
            row_i = int'(wr_q) + k - 2;
            if (row_i < 0) begin
                slot_i = 0;
            end else if (row_i > H - 1) begin
                slot_i = int'(LAST_SLOT);
            end else begin
                slot_i = (int'(wr_slot_q) + k + 3) % NUM_SLOTS;
            end
            col_sel[k] = rd_data[3'(slot_i)];
        end
    end

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        wc_d        = wc_q;
        wr_d        = wr_q;
        phase_d     = phase_q;
        wr_slot_d   = wr_slot_q;
        win_d       = win_q;
        rd_addr     = '0;
        next_wr     = int'(wr_q);
        case (state_q)
            ST_IDLE: begin
                if (rows_ready(wrow_acc, 0)) begin
                    state_d     = ST_PRIME;
                    prime_cnt_d = 2'd0;
                end
            end
            ST_PRIME: begin
                case (prime_cnt_q)
                    2'd0: begin
                        rd_addr     = '0;
                        prime_cnt_d = 2'd1;
                    end
                    2'd1: begin
                        rd_addr = AW'(clamp(1, 0, W - 1));
                        for (int k = 0; k < 4; k++) begin
                            for (int j = 0; j < 4; j++) begin
                                win_d[k*4+j] = col_sel[k];
                            end
                        end
                        prime_cnt_d = 2'd2;
                    end
                    2'd2: begin
                        rd_addr = AW'(clamp(2, 0, W - 1));
                        for (int k = 0; k < 4; k++) begin
                            win_d[k*4+3] = col_sel[k];
                        end
                        state_d = ST_STREAM;
                        wc_d    = '0;
                    end
                    default: begin
                        // Parked here until the rows for the next window row have arrived.
                        if (rows_ready(wrow_acc, int'(wr_q))) begin
                            prime_cnt_d = 2'd0;
                        end
                    end
                endcase
            end
            ST_STREAM: begin
                // The read register always holds column wc+2, the one shifted in on the next handshake.
                rd_addr = AW'(clamp(int'(wc_q) + 2, 0, W - 1));
                if (hs) begin
                    rd_addr = AW'(clamp(int'(wc_q) + 3, 0, W - 1));
                    for (int k = 0; k < 4; k++) begin
                        for (int j = 0; j < 3; j++) begin
                            win_d[k*4+j] = win_q[k*4+j+1];
                        end
                        win_d[k*4+3] = col_sel[k];
                    end
                    if (wc_q == WC_LAST) begin
                        wc_d = '0;
                        if (frame_done) begin
                            state_d   = ST_IDLE;
                            wr_d      = '0;
                            phase_d   = '0;
                            wr_slot_d = '0;
                        end else begin
                            if (phase_q == PHASE_LAST) begin
                                wr_d      = wr_q + 1'b1;
                                phase_d   = '0;
                                wr_slot_d = (wr_slot_q == 3'd4) ? 3'd0 : wr_slot_q + 3'd1;
                                next_wr   = int'(wr_q) + 1;
                            end else begin
                                phase_d = phase_q + 1'b1;
                            end
                            state_d     = ST_PRIME;
                            prime_cnt_d = rows_ready(wrow_acc, next_wr) ? 2'd0 : 2'd3;
                        end
                    end else begin
                        wc_d = wc_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_STREAM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prime_cnt_q <= '0;
            wc_q        <= '0;
            wr_q        <= '0;
            phase_q     <= '0;
            wr_slot_q   <= '0;
            wcol_q      <= '0;
            wrow_q      <= '0;
            w_slot_q    <= '0;
            src_ready_q <= 1'b1;
            valid_q     <= 1'b0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            wc_q        <= wc_d;
            wr_q        <= wr_d;
            phase_q     <= phase_d;
            wr_slot_q   <= wr_slot_d;
            wcol_q      <= wcol_d;
            wrow_q      <= wrow_d;
            w_slot_q    <= w_slot_d;
            src_ready_q <= src_ready_d;
            valid_q     <= valid_d;
            win_q       <= win_d;
        end
    end

`ifdef BICUBIC_FEEDER_LAST_EN
    logic last_q, last_d;

    assign last_d = valid_d && (wr_d == ROW_LAST) && (phase_d == PHASE_LAST) && (wc_d == WC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign bf_req_last = last_q;
`endif

    assign src_ready    = src_ready_q;
    assign bf_req_valid = valid_q;
    assign p1  = win_q[0];
    assign p2  = win_q[1];
    assign p3  = win_q[2];
    assign p4  = win_q[3];
    assign p5  = win_q[4];
    assign p6  = win_q[5];
    assign p7  = win_q[6];
    assign p8  = win_q[7];
    assign p9  = win_q[8];
    assign p10 = win_q[9];
    assign p11 = win_q[10];
    assign p12 = win_q[11];
    assign p13 = win_q[12];
    assign p14 = win_q[13];
    assign p15 = win_q[14];
    assign p16 = win_q[15];

endmodule

// File: tb/tb_bicubic_window_feeder.sv
// tb/tb_bicubic_window_feeder.sv - scoreboard bench for bicubic_window_feeder (W=4, H=3 and a W=4, H=8 stall instance)
module tb_bicubic_window_feeder;

    localparam int W = 4;
    localparam int H = 3;
    localparam int NWIN = 4 * H * (W + 1);

    typedef int pix16_t [16];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic [7:0] src_data = '0;
    logic       bf_req_valid;
    logic       bcci_req_ready = 1'b1;
    logic       bf_req_last;
    logic [7:0] p [16];

    logic       s8_valid = 1'b0;
    logic       s8_ready;
    logic [7:0] s8_data = '0;
    logic       v8;
    logic       r8 = 1'b0;
    logic       last8;
    logic [7:0] q [16];

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bicubic_window_feeder #(.CHANNEL_WIDTH(8), .BLOCK_SIZE(W), .SRC_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .bf_req_valid(bf_req_valid), .bcci_req_ready(bcci_req_ready),
`ifdef BICUBIC_FEEDER_LAST_EN
        .bf_req_last(bf_req_last),
`endif
        .p1(p[0]), .p2(p[1]), .p3(p[2]), .p4(p[3]), .p5(p[4]), .p6(p[5]), .p7(p[6]), .p8(p[7]),
        .p9(p[8]), .p10(p[9]), .p11(p[10]), .p12(p[11]), .p13(p[12]), .p14(p[13]), .p15(p[14]), .p16(p[15])
    );

    bicubic_window_feeder #(.CHANNEL_WIDTH(8), .BLOCK_SIZE(4), .SRC_HEIGHT(8)) dut8 (
        .clk(clk), .rst(rst), .src_valid(s8_valid), .src_ready(s8_ready), .src_data(s8_data),
        .bf_req_valid(v8), .bcci_req_ready(r8),
`ifdef BICUBIC_FEEDER_LAST_EN
        .bf_req_last(last8),
`endif
        .p1(q[0]), .p2(q[1]), .p3(q[2]), .p4(q[3]), .p5(q[4]), .p6(q[5]), .p7(q[6]), .p8(q[7]),
        .p9(q[8]), .p10(q[9]), .p11(q[10]), .p12(q[11]), .p13(q[12]), .p14(q[13]), .p15(q[14]), .p16(q[15])
    );

`ifndef BICUBIC_FEEDER_LAST_EN
    assign bf_req_last = 1'b0;
    assign last8 = 1'b0;
`endif

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [127:0] cur_win();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = p[i];
        return v;
    endfunction

    function automatic logic [127:0] exp_win(input int wr, input int wc);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                v[(4*k+j)*8 +: 8] = 8'(16 * clampi(wr - 2 + k, 0, H - 1) + clampi(wc - 2 + j, 0, W - 1));
        return v;
    endfunction

    function automatic logic [127:0] pack16(input pix16_t a);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(a[i]);
        return v;
    endfunction

    task automatic run_frame(input int bp_at, input int bp_len, output int nwin, output int dt,
                             output logic [127:0] first_win, output logic [127:0] last_win);
        int t_acc7, t_valid, idx, g1, g2, bp_cnt, extra;
        logic seen_valid;
        logic [127:0] held, got, want;
        for (int wr = 0; wr < H; wr++)
            for (int ph = 0; ph < 4; ph++)
                for (int wc = 0; wc <= W; wc++)
                    exp_q.push_back(exp_win(wr, wc));
        t_acc7 = -100; t_valid = -1; nwin = 0; seen_valid = 1'b0; bp_cnt = 0; held = '0;
        first_win = '0; last_win = '0;
        fork
            begin
                idx = 0; g1 = 0;
                while (idx < W * H && g1 < 300) begin
                    @(posedge clk); #1;
                    src_valid = 1'b1;
                    src_data = 8'(16 * (idx / W) + idx % W);
                    @(negedge clk);
                    if (src_ready) begin
                        if (idx == W + 3) t_acc7 = cyc + 1;
                        idx++;
                    end
                    g1++;
                end
                @(posedge clk); #1;
                src_valid = 1'b0;
                total_cnt++;
                if (idx !== W * H) $display("FAIL src_accepted: got %0d, expected %0d", idx, W * H);
                else pass_cnt++;
            end
            begin
                g2 = 0;
                while (nwin < NWIN && g2 < 3000) begin
                    @(negedge clk);
                    if (bf_req_valid && !seen_valid) begin
                        seen_valid = 1'b1;
                        t_valid = cyc;
                    end
                    if (!bcci_req_ready) begin
                        total_cnt++;
                        if (bf_req_valid !== 1'b1 || cur_win() !== held)
                            $display("FAIL bp_hold: valid %0b win %h, expected valid 1 win %h", bf_req_valid, cur_win(), held);
                        else pass_cnt++;
                    end
                    if (bf_req_valid && bcci_req_ready) begin
                        got = cur_win();
                        want = exp_q.pop_front();
                        total_cnt++;
                        if (got !== want) $display("FAIL window %0d: got %h, expected %h", nwin, got, want);
                        else pass_cnt++;
`ifdef BICUBIC_FEEDER_LAST_EN
                        total_cnt++;
                        if (bf_req_last !== (nwin == NWIN - 1))
                            $display("FAIL last_flag window %0d: got %0b, expected %0b", nwin, bf_req_last, (nwin == NWIN - 1));
                        else pass_cnt++;
`endif
                        if (nwin == 0) first_win = got;
                        if (nwin == NWIN - 1) last_win = got;
                        nwin++;
                    end
                    @(posedge clk); #1;
                    if (nwin == bp_at && bp_cnt < bp_len) begin
                        if (bp_cnt == 0) held = cur_win();
                        bcci_req_ready = 1'b0;
                        bp_cnt++;
                    end else begin
                        bcci_req_ready = 1'b1;
                    end
                    g2++;
                end
            end
        join
        bcci_req_ready = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bf_req_valid) extra++;
        end
        total_cnt++;
        if (nwin !== NWIN) $display("FAIL window_count: got %0d, expected %0d", nwin, NWIN);
        else pass_cnt++;
        total_cnt++;
        if (extra !== 0) $display("FAIL extra_windows: got %0d, expected 0", extra);
        else pass_cnt++;
        exp_q.delete();
        dt = t_valid - t_acc7;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_valid = 1'b0;
        s8_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bf_req_valid !== 1'b0) $display("FAIL reset_valid: got %0b, expected 0", bf_req_valid);
        else pass_cnt++;
        total_cnt++;
        if (cur_win() !== 128'd0) $display("FAIL reset_window: got %h, expected 0", cur_win());
        else pass_cnt++;
        total_cnt++;
        if (src_ready !== 1'b1 || s8_ready !== 1'b1)
            $display("FAIL reset_src_ready: got %0b/%0b, expected 1/1", src_ready, s8_ready);
        else pass_cnt++;
        total_cnt++;
        if (bf_req_last !== 1'b0 || last8 !== 1'b0) $display("FAIL reset_last: got %0b, expected 0", bf_req_last);
        else pass_cnt++;
    endtask

    task automatic test_full_frame();
        int nwin, dt;
        logic [127:0] fw, lw;
        pix16_t fv, lv;
        fv = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 16, 16, 16, 17};
        lv = '{2, 3, 3, 3, 18, 19, 19, 19, 34, 35, 35, 35, 34, 35, 35, 35};
        run_frame(-1, 0, nwin, dt, fw, lw);
        total_cnt++;
        if (dt !== 3) $display("FAIL first_valid_latency: got %0d, expected 3", dt);
        else pass_cnt++;
        total_cnt++;
        if (fw !== pack16(fv)) $display("FAIL first_window: got %h, expected %h", fw, pack16(fv));
        else pass_cnt++;
        total_cnt++;
        if (lw !== pack16(lv)) $display("FAIL final_window: got %h, expected %h", lw, pack16(lv));
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int nwin, dt;
        logic [127:0] fw, lw;
        run_frame(7, 5, nwin, dt, fw, lw);
        total_cnt++;
        if (dt !== 3) $display("FAIL bp_first_valid_latency: got %0d, expected 3", dt);
        else pass_cnt++;
    endtask

    task automatic test_src_stall();
        int acc, idx;
        acc = 0; idx = 0;
        r8 = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            s8_valid = 1'b1;
            s8_data = 8'(16 * (idx / 4) + idx % 4);
            @(negedge clk);
            if (s8_ready) begin
                acc++;
                idx++;
            end
        end
        @(posedge clk); #1;
        s8_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (acc !== 12) $display("FAIL stall_accepted: got %0d, expected 12", acc);
        else pass_cnt++;
        total_cnt++;
        if (s8_ready !== 1'b0) $display("FAIL stall_ready: got %0b, expected 0", s8_ready);
        else pass_cnt++;
        total_cnt++;
        if (v8 !== 1'b1 || q[12] !== 8'd16 || q[15] !== 8'd17)
            $display("FAIL stall_window: valid %0b p13 %0d p16 %0d, expected 1 16 17", v8, q[12], q[15]);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int acc, nwin, dt;
        logic [127:0] fw, lw;
        pix16_t fv;
        fv = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 16, 16, 16, 17};
        acc = 0;
        while (acc < 7) begin
            @(posedge clk); #1;
            src_valid = 1'b1;
            src_data = 8'(8'hA0 + acc);
            @(negedge clk);
            if (src_ready) acc++;
        end
        @(posedge clk); #1;
        src_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bf_req_valid !== 1'b0 || src_ready !== 1'b1)
            $display("FAIL midreset_state: valid %0b ready %0b, expected 0 1", bf_req_valid, src_ready);
        else pass_cnt++;
        run_frame(-1, 0, nwin, dt, fw, lw);
        total_cnt++;
        if (fw !== pack16(fv)) $display("FAIL midreset_first_window: got %h, expected %h", fw, pack16(fv));
        else pass_cnt++;
        total_cnt++;
        if (dt !== 3) $display("FAIL midreset_latency: got %0d, expected 3", dt);
        else pass_cnt++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_src_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
